mini_alu: RTL and testbench

- Self-contained 8-bit-PC microsequencer/ALU for board bring-up.
- Fetches 28-bit instructions from an internal program ROM and executes them against a 256-entry x 16-bit register file.
- Drives eight LEDs from the LED instruction.
- Top-level block; its only I/O is the clock, reset and LED bus.

---
 rtl/mini_alu_pkg.sv | 43 ++++
 rtl/mini_alu_regfile.sv | 26 ++
 rtl/mini_alu_rom.sv | 43 ++++
 rtl/mini_alu.sv | 108 ++++++++++
 tb/tb_mini_alu.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/mini_alu_pkg.sv
// mini_alu shared definitions: opcodes, field slices,
// register names and the instruction encoder.
package mini_alu_pkg;

  localparam int IW = 28;

  localparam logic [3:0] NOP  = 4'd0;
  localparam logic [3:0] LED  = 4'd1;
  localparam logic [3:0] BLE  = 4'd2;
  localparam logic [3:0] STO  = 4'd3;
  localparam logic [3:0] ADD  = 4'd4;
  localparam logic [3:0] JMP  = 4'd5;
  localparam logic [3:0] SUB  = 4'd6;
  localparam logic [3:0] SMUL = 4'd7;

  localparam int OP_HI  = 27;
  localparam int OP_LO  = 24;
  localparam int DST_HI = 23;
  localparam int DST_LO = 16;
  localparam int S1_HI  = 15;
  localparam int S1_LO  = 8;
  localparam int S0_HI  = 7;
  localparam int S0_LO  = 0;

  localparam logic [7:0] R0 = 8'd0;
  localparam logic [7:0] R1 = 8'd1;
  localparam logic [7:0] R2 = 8'd2;
  localparam logic [7:0] R3 = 8'd3;
  localparam logic [7:0] R4 = 8'd4;
  localparam logic [7:0] R5 = 8'd5;
  localparam logic [7:0] R6 = 8'd6;
  localparam logic [7:0] R7 = 8'd7;

  function automatic logic [IW-1:0] mk(
    input logic [3:0] op,
    input logic [7:0] dst,
    input logic [7:0] s1,
    input logic [7:0] s0
  );
    return {op, dst, s1, s0};
  endfunction

endpackage

// File: rtl/mini_alu_regfile.sv
// mini_alu register file: two async reads, one sync write.
// Contents are deliberately not reset.
module mini_alu_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra0,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd0
);

  logic [DATA_W-1:0] regs [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) regs[wa] <= wd;
  end

  assign rd1 = regs[ra1];
  assign rd0 = regs[ra0];

endmodule

// File: rtl/mini_alu_rom.sv
// mini_alu program ROM. Image 0 is the LED counter,
// image 1 is an ALU corner-case program.
module mini_alu_rom
  import mini_alu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int IMAGE  = 0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IW-1:0]     data
);

  always_comb begin
    data = '0;
    if (IMAGE == 1) begin
      unique case (addr)
        8'd1:    data = mk(STO, R1, 8'h00, 8'h01);
        8'd2:    data = mk(STO, R0, 8'h00, 8'h00);
        8'd3:    data = mk(SUB, R4, R0, R1);
        8'd4:    data = mk(ADD, R5, R4, R1);
        8'd5:    data = mk(STO, R6, 8'h00, 8'hFE);
        8'd6:    data = mk(STO, R7, 8'h00, 8'h03);
        8'd7:    data = mk(SMUL, R2, R6, R7);
        8'd8:    data = mk(4'hF, R2, R1, R0);
        8'd9:    data = mk(LED, R0, R2, R0);
        default: data = '0;
      endcase
    end else begin
      unique case (addr)
        8'd1:    data = mk(STO, R1, 8'h00, 8'h01);
        8'd2:    data = mk(STO, R2, 8'h00, 8'h00);
        8'd3:    data = mk(STO, R3, 8'h00, 8'h05);
        8'd4:    data = mk(ADD, R2, R2, R1);
        8'd5:    data = mk(LED, R0, R2, R0);
        8'd6:    data = mk(BLE, 8'd4, R2, R3);
        8'd7:    data = mk(STO, R2, 8'h00, 8'h00);
        8'd8:    data = mk(JMP, 8'd4, R0, R0);
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/mini_alu.sv
// mini_alu top: PC/IR two-stage sequencer, decode,
// ALU and LED register.
module mini_alu
  import mini_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IMAGE  = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] oLed
);

  logic [ADDR_W-1:0] pc;
  logic [IW-1:0]     ir;
  logic [IW-1:0]     rom_q;

  logic [3:0]        op;
  logic [7:0]        dst;
  logic [7:0]        s1;
  logic [7:0]        s0;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd0;

  logic              we;
  logic [DATA_W-1:0] wd;
  logic              taken;
  logic              led_we;
  logic signed [DATA_W-1:0] prod;

  assign op  = ir[OP_HI:OP_LO];
  assign dst = ir[DST_HI:DST_LO];
  assign s1  = ir[S1_HI:S1_LO];
  assign s0  = ir[S0_HI:S0_LO];

  mini_alu_rom #(
    .ADDR_W(ADDR_W),
    .IMAGE (IMAGE)
  ) u_rom (
    .addr(pc),
    .data(rom_q)
  );

  mini_alu_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rf (
    .clk(Clock),
    .we (we),
    .wa (dst),
    .wd (wd),
    .ra1(s1),
    .ra0(s0),
    .rd1(rd1),
    .rd0(rd0)
  );

  assign prod = $signed(rd1[7:0]) * $signed(rd0[7:0]);

  // Reset gates the write so an aborted instruction leaves no trace.
  always_comb begin
    we     = 1'b0;
    wd     = '0;
    taken  = 1'b0;
    led_we = 1'b0;
    unique case (1'b1)
      (op == LED):  led_we = 1'b1;
      (op == BLE):  taken = (rd1 <= rd0);
      (op == STO): begin
        we = ~Reset;
        wd = {s1, s0};
      end
      (op == ADD): begin
        we = ~Reset;
        wd = rd1 + rd0;
      end
      (op == JMP):  taken = 1'b1;
      (op == SUB): begin
        we = ~Reset;
        wd = rd1 - rd0;
      end
      (op == SMUL): begin
        we = ~Reset;
        wd = prod;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc   <= '0;
      ir   <= '0;
      oLed <= 8'h00;
    end else begin
      if (taken) begin
        pc <= dst;
        ir <= '0;
      end else begin
        pc <= pc + 1'b1;
        ir <= rom_q;
      end
      if (led_we) oLed <= rd1[7:0];
    end
  end

endmodule

// File: tb/tb_mini_alu.sv
// Directed bench for mini_alu: LED program timing,
// branch squash, reset abort and ALU corner cases.
module tb_mini_alu;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       rb    = 1'b1;
  logic [7:0] oLed;
  logic [7:0] led_b;

  int passed = 0;
  int total  = 0;
  int ecnt   = 0;

  always #5 Clock = ~Clock;

  mini_alu dut (
    .Clock(Clock),
    .Reset(Reset),
    .oLed (oLed)
  );

  mini_alu #(.IMAGE(1)) dut_b (
    .Clock(Clock),
    .Reset(rb),
    .oLed (led_b)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
    ecnt++;
  endtask

  task automatic tick_to(input int n);
    while (ecnt < n) tick();
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s got %h want %h", tag, obs, exp);
  endtask

  initial begin
    // reset hold
    Reset = 1'b1;
    repeat (5) tick();
    chk("rst_led", 32'(oLed), 32'h00);
    chk("rst_pc", 32'(dut.pc), 32'h0);
    chk("rst_ir", 32'(dut.ir), 32'h0);

    // first LED update on edge 7
    Reset = 1'b0;
    ecnt  = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("pre_led_e%0d", e), 32'(oLed), 32'h00);
    end
    tick();
    chk("led_e7", 32'(oLed), 32'h01);

    // BLE taken squashes the fetched word
    tick();
    chk("sq_pc_e8", 32'(dut.pc), 32'd4);
    chk("sq_ir_e8", 32'(dut.ir), 32'h0);
    chk("sq_r2_e8", 32'(dut.u_rf.regs[2]), 32'd1);
    tick();
    chk("sq_r2_e9", 32'(dut.u_rf.regs[2]), 32'd1);
    chk("sq_pc_e9", 32'(dut.pc), 32'd5);
    tick();
    chk("r2_e10", 32'(dut.u_rf.regs[2]), 32'd2);

    tick_to(11);
    chk("led_e11", 32'(oLed), 32'h02);
    tick_to(14);
    chk("led_e14", 32'(oLed), 32'h02);
    tick_to(15);
    chk("led_e15", 32'(oLed), 32'h03);
    tick_to(19);
    chk("led_e19", 32'(oLed), 32'h04);
    tick_to(23);
    chk("led_e23", 32'(oLed), 32'h05);

    // equality 5<=5 is taken
    tick_to(24);
    chk("ble_eq_pc", 32'(dut.pc), 32'd4);
    chk("ble_eq_ir", 32'(dut.ir), 32'h0);
    tick_to(27);
    chk("led_e27", 32'(oLed), 32'h06);

    // 6<=5 false falls through
    tick_to(28);
    chk("ble_nt_pc", 32'(dut.pc), 32'd8);
    chk("ble_nt_ir", 32'(dut.ir), 32'h3020000);
    tick_to(29);
    chk("sto_r2_e29", 32'(dut.u_rf.regs[2]), 32'd0);
    tick_to(32);
    chk("led_e32", 32'(oLed), 32'h06);
    tick_to(33);
    chk("led_e33", 32'(oLed), 32'h01);

    // reset on the LED edge aborts it
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    ecnt  = 0;
    tick_to(10);
    chk("ra_led_e10", 32'(oLed), 32'h01);
    Reset = 1'b1;
    tick();
    chk("ra_led_e11", 32'(oLed), 32'h00);
    chk("ra_pc", 32'(dut.pc), 32'h0);
    chk("ra_ir", 32'(dut.ir), 32'h0);
    Reset = 1'b0;
    ecnt  = 0;
    tick_to(6);
    chk("rs_led_e6", 32'(oLed), 32'h00);
    tick_to(7);
    chk("rs_led_e7", 32'(oLed), 32'h01);
    tick_to(11);
    chk("rs_led_e11", 32'(oLed), 32'h02);

    // ALU corner image
    rb   = 1'b0;
    ecnt = 0;
    tick_to(5);
    chk("sub_wrap", 32'(dut_b.u_rf.regs[4]), 32'hFFFF);
    tick_to(6);
    chk("add_wrap", 32'(dut_b.u_rf.regs[5]), 32'h0000);
    tick_to(9);
    chk("smul_neg", 32'(dut_b.u_rf.regs[2]), 32'hFFFA);
    tick_to(10);
    chk("opf_r2", 32'(dut_b.u_rf.regs[2]), 32'hFFFA);
    chk("opf_pc", 32'(dut_b.pc), 32'd10);
    chk("opf_led", 32'(led_b), 32'h00);
    tick_to(11);
    chk("alu_led", 32'(led_b), 32'hFA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
